vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Raster scan generator and pixel output stage for the VGA path. It produces the pixel coordinates (oCoord_X, oCoord_Y) that every object drawer consumes. It takes back the drawer's registered drawing_request and RGB, and drives the aligned VGA sync, blank and colour outputs. It is the coordinate source and the pixel sink at the two ends of the drawer interface.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- BG_COLOR, 8'h00, colour output where no object requests drawing

Ports:
- CLK  in  1  pixel clock (25 MHz for the defaults); the block's only clock
- RESET  in  1  asynchronous, active-high reset
- oCoord_X  out  11  current horizontal count, 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800)
- oCoord_Y  out  11  current vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- drawing_request  in  1  object drawer request, registered by the drawer one clock after coordinates
- obj_RGB  in  8  object colour, same timing as drawing_request
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high during the visible region
- VGA_RGB  out  8  final pixel colour
- frame_start  out  1  one-clock pulse, coincident with oCoord = (0,0)

## Operation
- Stage 0, counters: h_cnt and v_cnt are registers that drive oCoord_X and oCoord_Y directly.
  - h_cnt increments every clock and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt wraps, and wraps from V_TOTAL-1 to 0.
- Stage-0 decode:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for h_cnt 656..751
  - vs = !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for v_cnt 490..491
- Stage 1, delay: active, hs and vs are registered once (active_d1, hs_d1, vs_d1). This matches the drawer's one-clock register.
- Stage 2, output register:
  - VGA_HS <= hs_d1
  - VGA_VS <= vs_d1
  - VGA_BLANK_N <= active_d1
  - VGA_RGB <= !active_d1 ? 8'h00 : (drawing_request ? obj_RGB : BG_COLOR)
- Blanking is enforced here. drawing_request outside the active region never reaches VGA_RGB. Drawers see raw counts up to 799/524.
- frame_start is registered from "next counter state == (0,0)". It therefore goes high in the same cycle oCoord becomes (0,0).
- Counters are free-running. The block has no enable, no stall and no programmable registers.

## Timing
- Reset values (while RESET is high and in the first cycle after release):
  - oCoord_X = 0, oCoord_Y = 0
  - VGA_HS = 1, VGA_VS = 1
  - VGA_BLANK_N = 0, VGA_RGB = 0
  - frame_start = 0, all delay registers inactive
- The first frame after reset starts at (0,0) without a frame_start pulse. The first pulse comes at the next wrap, exactly 420000 clocks after the first clock edge with RESET low.
- Latency:
  - coordinate to pins: 2 clocks
  - drawing_request/obj_RGB to VGA_RGB: 1 clock
- Pixel (x,y) appears on VGA_RGB in the cycle where the pins reflect stage-0 count (x,y), two clocks after oCoord = (x,y).
- Line period 800 clocks; frame period 420000 clocks. VGA_HS low for 96 consecutive clocks per line. VGA_VS low for 1600 consecutive clocks per frame.
- Simultaneous wraps: at h_cnt = 799 and v_cnt = 524, the next state is (0,0) and frame_start pulses in that cycle.
- Reset asserted mid-frame: all outputs go to reset values asynchronously. Scanning restarts from (0,0) on release, and no partial-line state is retained.

## Test plan
- Reset release: hold RESET 5 clocks, release. oCoord = (0,0), then X counts 1,2,… each clock; VGA_HS=1, VGA_BLANK_N=0 for the first 2 clocks, then VGA_BLANK_N=1.
- Line/frame geometry: run 2 frames.
  - Line period 800 clocks.
  - VGA_HS low exactly when the 2-clock-delayed h_cnt is 656..751.
  - VGA_VS low for lines 490–491 (1600 clocks).
  - VGA_BLANK_N high 640×480 clocks per frame.
  - frame_start pulses once per 420000 clocks, with none in the first frame.
- Colour mux: drive drawing_request=1, obj_RGB=8'hE0 only in the cycle after oCoord=(100,50). VGA_RGB=8'hE0 exactly one clock later, and BG_COLOR (8'h00) on the neighbouring pixels.
- Blank suppression: drive drawing_request=1, obj_RGB=8'hFF constantly. VGA_RGB=8'hFF only while VGA_BLANK_N=1, and 8'h00 for the entire horizontal and vertical blanking.
- Wrap corner: at oCoord=(799,524), the next clock gives oCoord=(0,0) and frame_start=1 for exactly one clock.
- Mid-frame reset: assert RESET at oCoord=(300,200) for 3 clocks. Outputs are at reset values immediately, and counting resumes from (0,0) after release.

Source files
------------

// File: rtl/vga_scan_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_gen
//
// Raster scan generator and pixel output stage of the VGA path. Free-running
// horizontal/vertical counters produce the pixel coordinates that every
// object drawer consumes. The drawers answer one clock later with a
// registered drawing_request / obj_RGB. This block delays its own sync and
// blank decode by one clock to line up with that answer. It then registers
// the aligned sync, blank and colour onto the pins.
//
// Pipeline:
//   stage 0 : h/v counters (oCoord_X/oCoord_Y) + combinational decode
//   stage 1 : decode delayed one clock (same latency as a drawer)
//   stage 2 : output registers; colour mux with blanking enforced
//
// Ports:
//   CLK             in   1   pixel clock, the only clock
//   RESET           in   1   asynchronous, active-high reset
//   oCoord_X        out  11  horizontal count 0..H_TOTAL-1
//   oCoord_Y        out  11  vertical count 0..V_TOTAL-1
//   drawing_request in   1   drawer request, one clock behind the coordinates
//   obj_RGB         in   8   drawer colour, same timing as drawing_request
//   VGA_HS          out  1   horizontal sync, active low
//   VGA_VS          out  1   vertical sync, active low
//   VGA_BLANK_N     out  1   high during the visible region
//   VGA_RGB         out  8   final pixel colour
//   frame_start     out  1   one-clock pulse when oCoord becomes (0,0)
// -----------------------------------------------------------------------------
module vga_scan_gen #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [10:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  input  logic        drawing_request,
  input  logic [7:0]  obj_RGB,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_RGB,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS        = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS        = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_SYNC_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // stage 0 state
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_frame_start;

  // stage 1 state
  logic        r_active_d1;
  logic        r_hs_d1;
  logic        r_vs_d1;

  // stage 2 state
  logic        r_vga_hs;
  logic        r_vga_vs;
  logic        r_vga_blank_n;
  logic [7:0]  r_vga_rgb;

  // stage 0 combinational
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_h_next;
  logic [10:0] w_v_next;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic [7:0]  w_pixel;

  // ---------------------------------------------------------------------------
  // Next counter state. The vertical count only moves on a horizontal wrap,
  // so both wraps coincide at the last pixel of the last line.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);

    if (w_h_wrap) begin
      w_h_next = '0;
    end else begin
      w_h_next = r_h_cnt + 11'd1;
    end

    if (w_h_wrap) begin
      if (w_v_wrap) begin
        w_v_next = '0;
      end else begin
        w_v_next = r_v_cnt + 11'd1;
      end
    end else begin
      w_v_next = r_v_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-0 decode of the current count.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_hs     = !((r_h_cnt >= H_SYNC_FIRST) && (r_h_cnt <= H_SYNC_LAST));
    w_vs     = !((r_v_cnt >= V_SYNC_FIRST) && (r_v_cnt <= V_SYNC_LAST));
  end

  // ---------------------------------------------------------------------------
  // Colour mux. It uses the stage-1 active flag because the drawer's request
  // refers to the same pixel as that flag. Anything requested outside the
  // visible region is forced to black here, not in the drawers.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!r_active_d1) begin
      w_pixel = 8'h00;
    end else if (drawing_request) begin
      w_pixel = obj_RGB;
    end else begin
      w_pixel = BG_COLOR;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: counters and frame_start.
  // frame_start looks at the next state, so it rises together with (0,0). The
  // reset state is already (0,0) without a pulse, so the first pulse marks the
  // start of the second frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_frame_start <= (w_h_next == 11'd0) && (w_v_next == 11'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: one-clock delay that matches the drawer's register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_active_d1 <= 1'b0;
      r_hs_d1     <= 1'b1;
      r_vs_d1     <= 1'b1;
    end else begin
      r_active_d1 <= w_active;
      r_hs_d1     <= w_hs;
      r_vs_d1     <= w_vs;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: pin registers. All pins change on the same edge, so sync, blank
  // and colour stay aligned to the same stage-0 count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_vga_hs      <= 1'b1;
      r_vga_vs      <= 1'b1;
      r_vga_blank_n <= 1'b0;
      r_vga_rgb     <= 8'h00;
    end else begin
      r_vga_hs      <= r_hs_d1;
      r_vga_vs      <= r_vs_d1;
      r_vga_blank_n <= r_active_d1;
      r_vga_rgb     <= w_pixel;
    end
  end

  assign oCoord_X    = r_h_cnt;
  assign oCoord_Y    = r_v_cnt;
  assign frame_start = r_frame_start;
  assign VGA_HS      = r_vga_hs;
  assign VGA_VS      = r_vga_vs;
  assign VGA_BLANK_N = r_vga_blank_n;
  assign VGA_RGB     = r_vga_rgb;

endmodule

// File: tb/tb_vga_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_gen
//
// Bench for vga_scan_gen. Instance "a" uses the default 640x480 timing and
// covers reset release, the horizontal geometry, the colour mux, blank
// suppression and reset in mid-frame. Instance "b" uses a scaled-down
// 15x10 raster. A full frame of it takes 150 clocks, so frame-level
// behaviour fits in a short run: frame_start, vertical sync, blank totals
// and the simultaneous wrap.
// -----------------------------------------------------------------------------
module tb_vga_scan_gen;

  logic        clk;
  logic        rst;

  logic        req_a;
  logic [7:0]  rgb_a;
  logic [10:0] ax, ay;
  logic        ahs, avs, ablank, afs;
  logic [7:0]  argb;

  logic        req_b;
  logic [7:0]  rgb_b;
  logic [10:0] bx, by;
  logic        bhs, bvs, bblank, bfs;
  logic [7:0]  brgb;

  int n_total = 0;
  int n_pass  = 0;

  vga_scan_gen dut_a (
    .CLK            (clk),
    .RESET          (rst),
    .oCoord_X       (ax),
    .oCoord_Y       (ay),
    .drawing_request(req_a),
    .obj_RGB        (rgb_a),
    .VGA_HS         (ahs),
    .VGA_VS         (avs),
    .VGA_BLANK_N    (ablank),
    .VGA_RGB        (argb),
    .frame_start    (afs)
  );

  // small raster: H 8+2+3+2 = 15, V 6+1+2+1 = 10, frame = 150 clocks
  vga_scan_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BG_COLOR(8'h00)
  ) dut_b (
    .CLK            (clk),
    .RESET          (rst),
    .oCoord_X       (bx),
    .oCoord_Y       (by),
    .drawing_request(req_b),
    .obj_RGB        (rgb_b),
    .VGA_HS         (bhs),
    .VGA_VS         (bvs),
    .VGA_BLANK_N    (bblank),
    .VGA_RGB        (brgb),
    .frame_start    (bfs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    logic       req;
    logic [7:0] rgb;
    logic       exp_hs;
    logic       exp_vs;
    logic       exp_blank;
    logic [7:0] exp_rgb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for coordinate", name);
  endtask

  // Wait (bounded) until dut_a shows coordinate (x,y); called at a negedge.
  task automatic wait_coord(input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50000; i++) begin
      if (ax == 11'(x) && ay == 11'(y)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit   ok;
    int   h, v, hp, vp;
    logic eb, ehs, evs;
    int   vs_low_b, blank_hi_b, fs_b;
    int   hs_low_a, blank_hi_a;
    logic [10:0] prev_x;

    //              x    y  req  rgb    hs    vs  blank  rgb
    vecs[0]  = '{100,  1, 1'b1, 8'hE0, 1'b1, 1'b1, 1'b1, 8'hE0};
    vecs[1]  = '{103,  1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 8'h00};
    vecs[2]  = '{639,  1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
    vecs[3]  = '{655,  1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{751,  1, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{799,  1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{640,  2, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{656,  2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{752,  2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{  0,  3, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
    vecs[10] = '{  3,  3, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 8'h00};

    rst   = 1'b1;
    req_a = 1'b0;
    rgb_a = 8'h00;
    req_b = 1'b1;
    rgb_b = 8'hFF;

    // ---------------- reset state ----------------
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_x", ax, 0);
    chk("rst_y", ay, 0);
    chk("rst_hs", ahs, 1);
    chk("rst_vs", avs, 1);
    chk("rst_blank", ablank, 0);
    chk("rst_rgb", argb, 0);
    chk("rst_fs", afs, 0);
    chk("rst_b_rgb", brgb, 0);
    $display("reset held 5 clocks: x=%0d y=%0d hs=%0b vs=%0b blank_n=%0b", ax, ay, ahs, avs, ablank);

    rst = 1'b0;
    #1;
    chk("rel_x", ax, 0);
    chk("rel_blank", ablank, 0);

    // ---------------- first 2 small frames, cycle-accurate ----------------
    vs_low_b   = 0;
    blank_hi_b = 0;
    fs_b       = 0;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      if (e <= 4) begin
        chk("rel_a_x", ax, e);
        chk("rel_a_y", ay, 0);
        chk("rel_a_hs", ahs, 1);
        chk("rel_a_blank", ablank, (e >= 2) ? 1 : 0);
        chk("rel_a_fs", afs, 0);
      end
      h = e % 15;
      v = (e / 15) % 10;
      if (e >= 2) begin
        hp  = (e - 2) % 15;
        vp  = ((e - 2) / 15) % 10;
        eb  = (hp < 8) && (vp < 6);
        ehs = !(hp >= 10 && hp <= 12);
        evs = !(vp >= 7 && vp <= 8);
      end else begin
        eb  = 1'b0;
        ehs = 1'b1;
        evs = 1'b1;
      end
      chk("b_x", bx, h);
      chk("b_y", by, v);
      chk("b_hs", bhs, ehs);
      chk("b_vs", bvs, evs);
      chk("b_blank", bblank, eb);
      chk("b_rgb", brgb, eb ? 8'hFF : 8'h00);
      chk("b_fs", bfs, (e % 150 == 0) ? 1 : 0);
      if (!bvs) vs_low_b++;
      if (bblank) blank_hi_b++;
      if (bfs) fs_b++;
    end
    chk("b_vs_low_total", vs_low_b, 60);
    chk("b_blank_total", blank_hi_b, 96);
    chk("b_fs_total", fs_b, 2);
    $display("small raster 2 frames: vs_low=%0d blank_hi=%0d frame_start=%0d", vs_low_b, blank_hi_b, fs_b);

    // ---------------- table-driven pixel vectors ----------------
    for (int i = 0; i < 11; i++) begin
      wait_coord(vecs[i].x, vecs[i].y, ok);
      if (!ok) begin
        timeout("vec_wait");
        break;
      end
      @(posedge clk);
      #1;
      req_a = vecs[i].req;
      rgb_a = vecs[i].rgb;
      @(posedge clk);
      #1;
      req_a = 1'b0;
      rgb_a = 8'h00;
      @(negedge clk);
      chk("vec_hs", ahs, vecs[i].exp_hs);
      chk("vec_vs", avs, vecs[i].exp_vs);
      chk("vec_blank", ablank, vecs[i].exp_blank);
      chk("vec_rgb", argb, vecs[i].exp_rgb);
      $display("vec %0d (%0d,%0d) req=%0b obj=%02h -> hs=%0b vs=%0b blank_n=%0b rgb=%02h",
               i, vecs[i].x, vecs[i].y, vecs[i].req, vecs[i].rgb, ahs, avs, ablank, argb);
    end

    // ---------------- colour mux at (100,50) ----------------
    wait_coord(99, 50, ok);
    if (!ok) timeout("mux_wait");
    @(posedge clk);             // oCoord = 100
    @(posedge clk);             // oCoord = 101: request for pixel 100
    #1;
    req_a = 1'b1;
    rgb_a = 8'hE0;
    @(negedge clk);
    chk("mux_left", argb, 8'h00);
    @(posedge clk);
    #1;
    req_a = 1'b0;
    rgb_a = 8'h00;
    @(negedge clk);
    chk("mux_hit", argb, 8'hE0);
    @(negedge clk);
    chk("mux_right", argb, 8'h00);
    $display("colour mux at (100,50): hit pixel rgb checked with obj=E0");

    // ---------------- blank suppression over one full line ----------------
    wait_coord(0, 51, ok);
    if (!ok) timeout("blank_wait");
    req_a      = 1'b1;
    rgb_a      = 8'hFF;
    hs_low_a   = 0;
    blank_hi_a = 0;
    prev_x     = ax;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      hp = (int'(ax) + 798) % 800;
      chk("line_x_step", ax, (int'(prev_x) + 1) % 800);
      chk("line_blank", ablank, (hp < 640) ? 1 : 0);
      chk("line_rgb", argb, (hp < 640) ? 8'hFF : 8'h00);
      chk("line_hs", ahs, (hp >= 656 && hp <= 751) ? 0 : 1);
      chk("line_fs", afs, 0);
      if (!ahs) hs_low_a++;
      if (ablank) blank_hi_a++;
      prev_x = ax;
    end
    chk("line_hs_low_total", hs_low_a, 96);
    chk("line_blank_total", blank_hi_a, 640);
    $display("full line with constant request: hs_low=%0d blank_hi=%0d", hs_low_a, blank_hi_a);

    // ---------------- reset in mid-frame ----------------
    wait_coord(300, 52, ok);
    if (!ok) timeout("mid_wait");
    chk("mid_pre_rgb", argb, 8'hFF);
    chk("mid_pre_blank", ablank, 1);
    rst = 1'b1;
    #1;
    chk("mid_x", ax, 0);
    chk("mid_y", ay, 0);
    chk("mid_hs", ahs, 1);
    chk("mid_vs", avs, 1);
    chk("mid_blank", ablank, 0);
    chk("mid_rgb", argb, 0);
    chk("mid_fs", afs, 0);
    chk("mid_b_x", bx, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_hold_x", ax, 0);
    chk("mid_hold_rgb", argb, 0);
    rst   = 1'b0;
    req_a = 1'b0;
    rgb_a = 8'h00;
    #1;
    chk("mid_rel_x", ax, 0);
    @(negedge clk);
    chk("mid_rel_x1", ax, 1);
    chk("mid_rel_y1", ay, 0);
    chk("mid_rel_blank1", ablank, 0);
    @(negedge clk);
    chk("mid_rel_x2", ax, 2);
    chk("mid_rel_blank2", ablank, 1);
    $display("mid-frame reset at (300,52): restart from (0,0)");

    // ---------------- simultaneous wrap on the small raster ----------------
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bx == 11'd14 && by == 11'd9) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("wrap_wait");
    chk("wrap_pre_fs", bfs, 0);
    @(negedge clk);
    chk("wrap_x", bx, 0);
    chk("wrap_y", by, 0);
    chk("wrap_fs", bfs, 1);
    @(negedge clk);
    chk("wrap_fs_off", bfs, 0);
    chk("wrap_x1", bx, 1);
    $display("wrap corner (14,9)->(0,0) on small raster with frame_start pulse");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
